oldland_prefetch: RTL and testbench

- Parametrised successor to the single-entry fetch unit.
- Decouples instruction memory from decode with a DEPTH-entry prefetch queue, a req/ack memory handshake and a configurable reset vector.
- Keeps the partial-decode stall: load/store and branch classes (instr[31:30] of 01 or 10) cause NOPs to be issued until the stall is cleared.
- Sits between the instruction bus and oldland decode.

---
 rtl/oldland_prefetch.sv | 116 +++++++++++
 tb/tb_oldland_prefetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_prefetch.sv
// Oldland prefetch unit: DEPTH-entry instruction queue between the instruction
// bus and decode, with partial-decode stall, branch flush and stale-ack discard.
`ifndef INSTR_NOP
`define INSTR_NOP 32'h00000000
`endif

module oldland_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] NOP_INSTR  = `INSTR_NOP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_clear,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_pc,
    output logic                   i_req,
    output logic [31:0]            i_addr,
    input  logic                   i_ack,
    input  logic [31:0]            i_data,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus_4,
    output logic [$clog2(DEPTH):0] queue_level
);
    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]  ONE  = (AW+1)'(1);

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [31:0]   fetch_pc;
    logic [31:0]   hold_addr;
    logic          stalled;
    logic          discard;
    logic          stalled_next;
    logic          push;
    logic          pop;

    assign stalled_next = stalled && !stall_clear;
    assign i_req        = !rst && (count < FULL);
    // While discarding, the bus must keep seeing the abandoned request's address.
    assign i_addr       = discard ? hold_addr : fetch_pc;
    assign push         = i_req && i_ack && !discard && !branch_taken;
    assign pop          = (count != '0) && !stalled_next && !branch_taken;
    assign pc_plus_4    = pc + 32'd4;
    assign queue_level  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail] <= i_data;
            pc_q[tail]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_pc    <= RESET_ADDR;
            hold_addr   <= RESET_ADDR;
            stalled     <= 1'b0;
            discard     <= 1'b0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            pc          <= RESET_ADDR - 32'd4;
        end else if (branch_taken) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_pc    <= branch_pc;
            stalled     <= 1'b0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            if (i_req && !i_ack) begin
                discard   <= 1'b1;
                hold_addr <= i_addr;
            end else begin
                discard   <= 1'b0;
            end
        end else begin
            if (i_req && i_ack) begin
                if (discard) begin
                    discard <= 1'b0;
                end else begin
                    tail     <= tail + AW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end

            if (pop) begin
                instr       <= data_q[head];
                pc          <= pc_q[head];
                instr_valid <= 1'b1;
                head        <= head + AW'(1);
                // Load/store and branch classes stall until a later stage clears it.
                stalled     <= (^data_q[head][31:30]) | stalled_next;
            end else begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
                stalled     <= stalled_next;
            end

            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_oldland_prefetch.sv
// Directed bench for oldland_prefetch: fetch/issue, stall hold-off, branch
// discard, same-cycle corner cases, reset mid-request and address wrap.
`timescale 1ns/1ps
module tb_oldland_prefetch;
    localparam logic [31:0] NOP = 32'h0C00_0000;
    localparam logic [31:0] RA  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_clear = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic        i_req;
    logic        i_ack;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [2:0]  queue_level;

    int          lat = 0;
    int          wait_cnt = 0;
    logic [31:0] ld_addr = 32'hffff_ffff;
    logic [31:0] br_addr = 32'hffff_ffff;
    int          n_pass = 0;
    int          n_total = 0;
    logic        found;
    int          k_found;

    oldland_prefetch #(.RESET_ADDR(RA), .DEPTH(4), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall_clear(stall_clear),
        .branch_taken(branch_taken), .branch_pc(branch_pc),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .pc_plus_4(pc_plus_4), .queue_level(queue_level)
    );

    always #5 clk = ~clk;

    // Memory: word = {class, addr[29:0]}, ack after lat waiting cycles.
    assign i_data = {(i_addr == ld_addr) ? 2'b01 : (i_addr == br_addr) ? 2'b10 : 2'b00,
                     i_addr[29:0]};
    assign i_ack  = i_req && (wait_cnt >= lat);

    always @(posedge clk) begin
        if (i_req && !i_ack) wait_cnt <= wait_cnt + 1;
        else                 wait_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    initial begin
        // Reset state and straight-line fetch with zero-wait memory
        tick; tick;
        chk("rst_instr", instr, NOP);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, RA - 32'd4);
        chk("rst_pc4", pc_plus_4, RA);
        chk("rst_level", queue_level, 0);
        chk("rst_req", i_req, 0);
        rst = 1'b0;
        #1;
        chk("rel_req", i_req, 1);
        chk("rel_addr", i_addr, 32'h100);
        tick;
        chk("e1_addr", i_addr, 32'h104);
        chk("e1_valid", instr_valid, 0);
        chk("e1_level", queue_level, 1);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("seq_valid", instr_valid, 1);
            chk("seq_pc", pc, RA + 4*k);
            chk("seq_instr", instr, RA + 4*k);
            chk("seq_pc4", pc_plus_4, RA + 4*k + 4);
            chk("seq_addr", i_addr, RA + 4*k + 8);
        end

        // Load at 0x104, stall_clear held off six cycles
        ld_addr = 32'h104;
        rst = 1'b1; tick; rst = 1'b0;
        tick; tick; tick;
        chk("ld_valid", instr_valid, 1);
        chk("ld_pc", pc, 32'h104);
        chk("ld_instr", instr, 32'h4000_0104);
        for (int k = 4; k <= 9; k++) begin
            tick;
            chk("stall_valid", instr_valid, 0);
            chk("stall_instr", instr, NOP);
            chk("stall_pc", pc, 32'h104);
            if (k == 6 || k == 9) begin
                chk("stall_level", queue_level, 4);
                chk("stall_req", i_req, 0);
            end
        end
        stall_clear = 1'b1; tick; stall_clear = 1'b0;
        chk("resume_valid", instr_valid, 1);
        chk("resume_pc", pc, 32'h108);
        chk("resume_level", queue_level, 3);
        tick;
        chk("resume_pc2", pc, 32'h10c);
        chk("resume_level2", queue_level, 3);
        tick;
        chk("resume_pc3", pc, 32'h110);

        // Branch coinciding with ack, then branch during an outstanding request
        ld_addr = 32'hffff_ffff;
        rst = 1'b1; tick; rst = 1'b0;
        tick; tick; tick;
        branch_taken = 1'b1; branch_pc = 32'h20;
        #1;
        chk("bsame_ack", i_ack, 1);
        chk("bsame_addr", i_addr, 32'h10c);
        tick;
        branch_taken = 1'b0; lat = 3;
        #1;
        chk("bsame_valid", instr_valid, 0);
        chk("bsame_instr", instr, NOP);
        chk("bsame_level", queue_level, 0);
        chk("bsame_next_addr", i_addr, 32'h20);
        chk("bsame_req", i_req, 1);
        tick;
        chk("b20_addr", i_addr, 32'h20);
        chk("b20_noack", i_ack, 0);
        branch_taken = 1'b1; branch_pc = 32'h400;
        tick;
        branch_taken = 1'b0;
        chk("disc_hold_addr", i_addr, 32'h20);
        chk("disc_req", i_req, 1);
        chk("disc_valid", instr_valid, 0);
        tick;
        chk("disc_hold_addr2", i_addr, 32'h20);
        chk("disc_ack", i_ack, 1);
        tick;
        chk("disc_new_addr", i_addr, 32'h400);
        chk("disc_level", queue_level, 0);
        chk("disc_valid2", instr_valid, 0);
        found = 1'b0;
        k_found = -1;
        for (int k = 0; k < 10 && !found; k++) begin
            tick;
            if (instr_valid) begin
                found = 1'b1;
                k_found = k;
            end
        end
        chk("br_found", found, 1);
        chk("br_lat", k_found, 4);
        chk("br_pc", pc, 32'h400);
        chk("br_instr", instr, 32'h400);

        // stall_clear in the same cycle a branch-class word is popped
        lat = 0; ld_addr = 32'h100; br_addr = 32'h104;
        rst = 1'b1; tick; rst = 1'b0;
        tick; tick;
        chk("sc_first_pc", pc, 32'h100);
        tick;
        chk("sc_stalled", instr_valid, 0);
        stall_clear = 1'b1; tick; stall_clear = 1'b0;
        chk("sc_pop_valid", instr_valid, 1);
        chk("sc_pop_pc", pc, 32'h104);
        chk("sc_pop_instr", instr, 32'h8000_0104);
        tick;
        chk("sc_kept", instr_valid, 0);
        tick;
        chk("sc_kept2", instr_valid, 0);
        chk("sc_level", queue_level, 4);
        stall_clear = 1'b1; tick; stall_clear = 1'b0;
        chk("sc_release_valid", instr_valid, 1);
        chk("sc_release_pc", pc, 32'h108);
        chk("sc_release_level", queue_level, 3);

        // Reset while a request waits for its ack
        lat = 20;
        tick; tick;
        chk("rm_req", i_req, 1);
        chk("rm_noack", i_ack, 0);
        chk("rm_addr", i_addr, 32'h118);
        rst = 1'b1;
        #1;
        chk("rm_req_comb", i_req, 0);
        tick;
        chk("rm_req_after", i_req, 0);
        chk("rm_level", queue_level, 0);
        chk("rm_instr", instr, NOP);
        chk("rm_valid", instr_valid, 0);
        chk("rm_pc", pc, RA - 32'd4);
        ld_addr = 32'hffff_ffff; br_addr = 32'hffff_ffff; lat = 0;
        rst = 1'b0;
        #1;
        chk("rm_restart_addr", i_addr, RA);
        chk("rm_restart_req", i_req, 1);
        tick; tick;
        chk("rm_restart_valid", instr_valid, 1);
        chk("rm_restart_pc", pc, RA);

        // Fetch address wraps past 0xfffffffc
        branch_taken = 1'b1; branch_pc = 32'hffff_fff8;
        tick;
        branch_taken = 1'b0;
        chk("wrap_addr0", i_addr, 32'hffff_fff8);
        tick;
        chk("wrap_addr1", i_addr, 32'hffff_fffc);
        tick;
        chk("wrap_addr2", i_addr, 32'h0);
        chk("wrap_pc0", pc, 32'hffff_fff8);
        chk("wrap_instr0", instr, 32'h3fff_fff8);
        chk("wrap_pc4_0", pc_plus_4, 32'hffff_fffc);
        tick;
        chk("wrap_pc1", pc, 32'hffff_fffc);
        chk("wrap_pc4_1", pc_plus_4, 32'h0);
        chk("wrap_addr3", i_addr, 32'h4);
        tick;
        chk("wrap_pc2", pc, 32'h0);
        chk("wrap_instr2", instr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
